// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, payload sizing and byte-lane mapping.
// Reused by the master so both ends agree on the TDR/RDR byte layout.
package i2c_pkg;

  localparam int unsigned I2C_NBY_MAX = 4;
  localparam int unsigned I2C_DATA_W  = 32;
  localparam int unsigned I2C_LANE_W  = 2;
  localparam int unsigned I2C_BIT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } i2c_state_e;

  // Bit position of bit `bit_idx` inside byte lane `lane` of the 32-bit payload word.
  function automatic logic [I2C_LANE_W+I2C_BIT_W-1:0] i2c_lane_bit(
    input logic [I2C_LANE_W-1:0] lane,
    input logic [I2C_BIT_W-1:0]  bit_idx
  );
    return {lane, bit_idx};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one bus line with single-cycle rise/fall pulses.
// Flops reset to 1 (idle bus level) so reset release never fakes an edge.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta    <= 1'b1;
      level_o <= 1'b1;
      last    <= 1'b1;
    end else begin
      meta    <= line_i;
      level_o <= meta;
      last    <= level_o;
    end
  end

  assign rise_c = level_o & ~last;
  assign fall_c = ~level_o & last;

endmodule

// File: rtl/i2c_slave.sv
// Oversampling I2C target: 7-bit address match, up to 4-byte write assembly and
// 4-byte read service, byte k of the payload word on bits [8k+7:8k].
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  inout  wire                   sda_io,
  input  logic [I2C_DATA_W-1:0] tx_data_i,
  output logic [I2C_DATA_W-1:0] rx_data_o,
  output logic [2:0]            rx_nby_o,
  output logic                  rx_valid_o,
  output logic                  busy_o
);

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk_i(clk_i), .rst_i(rst_i), .line_i(scl_i),
    .level_o(scl_q), .rise_c(scl_rise), .fall_c(scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk_i(clk_i), .rst_i(rst_i), .line_i(sda_io),
    .level_o(sda_q), .rise_c(sda_rise), .fall_c(sda_fall)
  );

  logic start_c, stop_c;
  assign start_c = sda_fall & scl_q;
  assign stop_c  = sda_rise & scl_q;

  i2c_state_e               state, state_nx;
  logic [I2C_BIT_W-1:0]     bit_cnt;
  logic [I2C_LANE_W-1:0]    idx;
  logic [2:0]               nby;
  logic [6:0]               byte_sh;
  logic [I2C_DATA_W-1:0]    rx_sh;
  logic [I2C_DATA_W-1:0]    tx_word;
  logic                     rw;
  logic                     armed;
  logic                     sda_low, sda_low_nx;
  logic                     rx_valid_nx, busy_nx;

  assign sda_io = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start_c) begin
      state_nx = ST_ADDR;
    end else if (stop_c) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR:  if (scl_rise && bit_cnt == 3'd0)
                    state_nx = (byte_sh == SLAVE_ADDR) ? ST_AACK : ST_IGNORE;
        ST_AACK:  if (scl_fall && sda_low) state_nx = rw ? ST_RDATA : ST_WDATA;
        ST_WDATA: if (scl_rise && bit_cnt == 3'd0) state_nx = ST_WACK;
        ST_WACK:  if (scl_fall && sda_low) state_nx = ST_WDATA;
        ST_RDATA: if (scl_fall && armed && bit_cnt == 3'd0) state_nx = ST_RACK;
        ST_RACK:  if (scl_rise) state_nx = sda_q ? ST_IGNORE : ST_RDATA;
        default:  state_nx = state;
      endcase
    end
  end

  // SDA drive: ACK slots span one SCL period fall-to-fall; read bits change on SCL fall.
  always_comb begin
    sda_low_nx = 1'b0;
    case (state)
      ST_AACK: begin
        sda_low_nx = sda_low;
        if (scl_fall)
          sda_low_nx = sda_low ? (rw & ~tx_word[i2c_lane_bit(idx, 3'd7)]) : 1'b1;
      end
      ST_WACK: begin
        sda_low_nx = sda_low;
        if (scl_fall) sda_low_nx = ~sda_low;
      end
      ST_RDATA: begin
        sda_low_nx = sda_low;
        if (scl_fall) begin
          if (!armed)              sda_low_nx = ~tx_word[i2c_lane_bit(idx, bit_cnt)];
          else if (bit_cnt == 3'd0) sda_low_nx = 1'b0;
          else                     sda_low_nx = ~tx_word[i2c_lane_bit(idx, bit_cnt - 3'd1)];
        end
      end
      default: sda_low_nx = 1'b0;
    endcase
    if (start_c || stop_c) sda_low_nx = 1'b0;
    rx_valid_nx = (start_c || stop_c) && (nby != 3'd0);
    busy_nx     = (state_nx != ST_IDLE);
  end

  // Datapath; write bytes are committed to their lane only once all 8 bits arrived.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt    <= 3'd7;
      idx        <= '0;
      nby        <= '0;
      byte_sh    <= '0;
      rx_sh      <= '0;
      tx_word    <= '0;
      rw         <= 1'b0;
      armed      <= 1'b0;
      sda_low    <= 1'b0;
      rx_data_o  <= '0;
      rx_nby_o   <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      sda_low    <= sda_low_nx;
      rx_valid_o <= rx_valid_nx;
      busy_o     <= busy_nx;
      if (rx_valid_nx) begin
        rx_data_o <= rx_sh;
        rx_nby_o  <= nby;
      end
      if (start_c) begin
        bit_cnt <= 3'd7;
        idx     <= '0;
        nby     <= '0;
        byte_sh <= '0;
        rx_sh   <= '0;
        armed   <= 1'b0;
      end else if (stop_c) begin
        nby <= '0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            byte_sh <= {byte_sh[5:0], sda_q};
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              rw      <= sda_q;
              tx_word <= tx_data_i;
            end
          end
          ST_AACK: if (scl_fall && sda_low && rw) begin
            armed   <= 1'b1;
            bit_cnt <= 3'd7;
          end
          ST_WDATA: if (scl_rise) begin
            byte_sh <= {byte_sh[5:0], sda_q};
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              rx_sh[{idx, 3'b000} +: 8] <= {byte_sh, sda_q};
              idx <= idx + 2'd1;
              if (nby != 3'(I2C_NBY_MAX)) nby <= nby + 3'd1;
            end
          end
          ST_RDATA: if (scl_fall) begin
            if (!armed)               armed   <= 1'b1;
            else if (bit_cnt != 3'd0) bit_cnt <= bit_cnt - 3'd1;
          end
          ST_RACK: if (scl_rise && !sda_q) begin
            idx     <= idx + 2'd1;
            bit_cnt <= 3'd7;
            armed   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged bus master plus a byte-list payload model.
module tb_i2c_slave;

  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        m_low;
  logic [31:0] tx_data;
  logic [31:0] rx_data;
  logic [2:0]  rx_nby;
  logic        rx_valid;
  logic        busy;
  wire         sda_bus;

  int n_checks = 0;
  int n_pass   = 0;
  int rv_cnt   = 0;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_io(sda_bus),
    .tx_data_i(tx_data), .rx_data_o(rx_data), .rx_nby_o(rx_nby),
    .rx_valid_o(rx_valid), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_valid) rv_cnt <= rv_cnt + 1;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start(output int lat);
    lat = -1;
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b1;
    for (int k = 1; k <= Q; k++) begin
      tick(1);
      if (busy && lat < 0) lat = k;
    end
    scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop(output int lat);
    lat = -1;
    m_low = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b0;
    for (int k = 1; k <= 2 * Q; k++) begin
      tick(1);
      if (rx_valid && lat < 0) lat = k;
    end
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; tick(Q);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    b = sda_bus;  tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(~ack);
  endtask

  // Full write transaction ending in STOP; returns ACK count and rx_valid latency.
  task automatic do_write(input logic [7:0] data[$], output int n_ack, output int rv_lat);
    int   lat;
    logic ack;
    bus_start(lat);
    send_byte(8'hA0, ack);
    n_ack = int'(ack);
    foreach (data[i]) begin
      send_byte(data[i], ack);
      n_ack += int'(ack);
    end
    bus_stop(rv_lat);
    tick(2);
  endtask

  // Reference: byte i lands in lane i mod 4 of a word cleared at START.
  function automatic logic [31:0] model_word(input logic [7:0] data[$]);
    logic [31:0] w = '0;
    foreach (data[i]) w[8 * (i % 4) +: 8] = data[i];
    return w;
  endfunction

  function automatic logic [2:0] model_nby(input int n);
    return 3'((n > 4) ? 4 : n);
  endfunction

  task automatic test_reset;
    rst = 1'b1; scl = 1'b1; m_low = 1'b0; tx_data = '0;
    tick(4);
    n_checks++; if (rx_data !== 32'h0) $display("FAIL reset_rx_data: got %h expected 00000000", rx_data); else n_pass++;
    n_checks++; if (rx_nby !== 3'd0) $display("FAIL reset_rx_nby: got %0d expected 0", rx_nby); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_flags: got valid=%b busy=%b expected 0 0", rx_valid, busy); else n_pass++;
    n_checks++; if (sda_bus !== 1'b1) $display("FAIL reset_sda: got %b expected 1", sda_bus); else n_pass++;
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_write_basic;
    logic [7:0] d[$] = '{8'h11, 8'h22, 8'h33};
    logic ack;
    int lat, n_ack, rv_lat, rv0;
    rv0 = rv_cnt;
    bus_start(lat);
    n_checks++; if (lat !== 3) $display("FAIL busy_latency: got %0d expected 3", lat); else n_pass++;
    send_byte(8'hA0, ack);
    n_ack = int'(ack);
    foreach (d[i]) begin
      send_byte(d[i], ack);
      n_ack += int'(ack);
    end
    n_checks++; if (n_ack !== 4) $display("FAIL write_acks: got %0d expected 4", n_ack); else n_pass++;
    bus_stop(rv_lat);
    tick(2);
    n_checks++; if (rv_lat !== 3) $display("FAIL rx_valid_latency: got %0d expected 3", rv_lat); else n_pass++;
    n_checks++; if (rx_data !== 32'h00332211) $display("FAIL write_data: got %h expected 00332211", rx_data); else n_pass++;
    n_checks++; if (rx_nby !== 3'd3) $display("FAIL write_nby: got %0d expected 3", rx_nby); else n_pass++;
    n_checks++; if (rv_cnt - rv0 !== 1) $display("FAIL write_pulses: got %0d expected 1", rv_cnt - rv0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL write_busy_end: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_addr_mismatch;
    logic ack;
    int lat, rv_lat, rv0;
    rv0 = rv_cnt;
    bus_start(lat);
    send_byte(8'hA2, ack);
    n_checks++; if (ack !== 1'b0) $display("FAIL mismatch_addr_ack: got ack=%b expected 0", ack); else n_pass++;
    send_byte(8'h77, ack);
    n_checks++; if (ack !== 1'b0 || busy !== 1'b1) $display("FAIL mismatch_ignore: got ack=%b busy=%b expected 0 1", ack, busy); else n_pass++;
    bus_stop(rv_lat);
    tick(2);
    n_checks++; if (rv_cnt - rv0 !== 0 || busy !== 1'b0) $display("FAIL mismatch_stop: got pulses=%0d busy=%b expected 0 0", rv_cnt - rv0, busy); else n_pass++;
    n_checks++; if (rx_data !== 32'h00332211) $display("FAIL mismatch_hold: got %h expected 00332211", rx_data); else n_pass++;
  endtask

  task automatic test_read;
    logic ack, b;
    logic [7:0] v;
    logic [7:0] exp_b[3] = '{8'h5A, 8'h3C, 8'hC3};
    int lat, rv_lat, rv0;
    rv0 = rv_cnt;
    tx_data = 32'hA5C33C5A;
    bus_start(lat);
    send_byte(8'hA1, ack);
    n_checks++; if (ack !== 1'b1) $display("FAIL read_addr_ack: got %b expected 1", ack); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      recv_byte(v, k < 2);
      n_checks++; if (v !== exp_b[k]) $display("FAIL read_byte%0d: got %h expected %h", k, v, exp_b[k]); else n_pass++;
    end
    read_bit(b);
    n_checks++; if (b !== 1'b1) $display("FAIL read_release: got %b expected 1", b); else n_pass++;
    bus_stop(rv_lat);
    tick(2);
    n_checks++; if (rv_cnt - rv0 !== 0 || busy !== 1'b0) $display("FAIL read_stop: got pulses=%0d busy=%b expected 0 0", rv_cnt - rv0, busy); else n_pass++;
  endtask

  task automatic test_wrap5;
    logic [7:0] d[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int n_ack, rv_lat;
    do_write(d, n_ack, rv_lat);
    n_checks++; if (n_ack !== 6) $display("FAIL wrap_acks: got %0d expected 6", n_ack); else n_pass++;
    n_checks++; if (rx_data !== 32'h04030205) $display("FAIL wrap_data: got %h expected 04030205", rx_data); else n_pass++;
    n_checks++; if (rx_nby !== 3'd4) $display("FAIL wrap_nby: got %0d expected 4", rx_nby); else n_pass++;
  endtask

  task automatic test_reset_midread;
    logic ack, b;
    logic [7:0] d[$];
    int lat, n_ack, rv_lat;
    tx_data = 32'hFFFFFF00;
    bus_start(lat);
    send_byte(8'hA1, ack);
    for (int k = 0; k < 3; k++) read_bit(b);
    n_checks++; if (sda_bus !== 1'b0) $display("FAIL midread_drive: got %b expected 0", sda_bus); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (sda_bus !== 1'b1) $display("FAIL midread_async_release: got %b expected 1", sda_bus); else n_pass++;
    n_checks++; if (rx_data !== 32'h0 || rx_nby !== 3'd0 || busy !== 1'b0 || rx_valid !== 1'b0)
      $display("FAIL midread_reset_outputs: got data=%h nby=%0d busy=%b valid=%b expected 0 0 0 0", rx_data, rx_nby, busy, rx_valid); else n_pass++;
    tick(3);
    rst = 1'b0;
    tick(3);
    bus_stop(rv_lat);
    tick(2);
    d = '{8'($urandom), 8'($urandom)};
    do_write(d, n_ack, rv_lat);
    n_checks++; if (rx_data !== model_word(d) || rx_nby !== 3'd2 || n_ack !== 3)
      $display("FAIL post_reset_write: got data=%h nby=%0d acks=%0d expected %h 2 3", rx_data, rx_nby, n_ack, model_word(d)); else n_pass++;
  endtask

  task automatic test_repeated_start;
    logic ack;
    logic [7:0] v;
    int lat, rv_lat, rv0;
    tx_data = $urandom;
    rv0 = rv_cnt;
    bus_start(lat);
    send_byte(8'hA0, ack);
    send_byte(8'hBE, ack);
    send_byte(8'hEF, ack);
    bus_start(lat);
    n_checks++; if (rv_cnt - rv0 !== 1) $display("FAIL rstart_pulse: got %0d expected 1", rv_cnt - rv0); else n_pass++;
    n_checks++; if (rx_data !== 32'h0000EFBE || rx_nby !== 3'd2)
      $display("FAIL rstart_data: got %h nby=%0d expected 0000efbe 2", rx_data, rx_nby); else n_pass++;
    send_byte(8'hA1, ack);
    recv_byte(v, 1'b0);
    n_checks++; if (ack !== 1'b1 || v !== tx_data[7:0]) $display("FAIL rstart_read: got ack=%b byte=%h expected 1 %h", ack, v, tx_data[7:0]); else n_pass++;
    bus_stop(rv_lat);
    tick(2);
    n_checks++; if (rv_cnt - rv0 !== 1) $display("FAIL rstart_total_pulses: got %0d expected 1", rv_cnt - rv0); else n_pass++;
  endtask

  task automatic test_random;
    logic ack;
    logic [7:0] v, e;
    logic [7:0] d[$];
    int n, n_ack, rv_lat, rv0, lat;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(6, 1);
      if (it % 2 == 0) begin
        d = {};
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        rv0 = rv_cnt;
        do_write(d, n_ack, rv_lat);
        n_checks++; if (rx_data !== model_word(d) || rx_nby !== model_nby(n) || n_ack !== n + 1 || rv_cnt - rv0 !== 1)
          $display("FAIL rand_write%0d: got data=%h nby=%0d acks=%0d pulses=%0d expected %h %0d %0d 1",
                   it, rx_data, rx_nby, n_ack, rv_cnt - rv0, model_word(d), model_nby(n), n + 1); else n_pass++;
      end else begin
        tx_data = $urandom;
        bus_start(lat);
        send_byte(8'hA1, ack);
        for (int k = 0; k < n; k++) begin
          recv_byte(v, k < n - 1);
          e = 8'(tx_data >> (8 * (k % 4)));
          n_checks++; if (v !== e || ack !== 1'b1) $display("FAIL rand_read%0d_byte%0d: got %h ack=%b expected %h 1", it, k, v, ack, e); else n_pass++;
        end
        bus_stop(rv_lat);
        tick(2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_basic;
    test_addr_mismatch;
    test_read;
    test_wrap5;
    test_reset_midread;
    test_repeated_start;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
